// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 (modified Booth) multiplier with an internal iteration counter,
// runtime signed/unsigned mode, a busy/done handshake and a held product register.
module booth_r4_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [2:0]         state
);

    // The iteration count is derived from WIDTH and cannot be overridden.
    localparam int ITER = WIDTH / 2 + 1;
    localparam int QW   = WIDTH + 2;
    localparam int AW   = WIDTH + 4;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_r4_mult_seq: WIDTH must be even and at least 4");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            fsm;
    logic [CW-1:0]     counter;

    logic [WIDTH-1:0]  a_cap;
    logic [WIDTH-1:0]  b_cap;
    logic              sm_cap;
    logic [QW-1:0]     mcand;
    logic [QW-1:0]     q;
    logic              qm1;
    logic [AW-1:0]     acc;

    logic [AW-1:0]     a_ext;
    logic [AW-1:0]     two_a;
    logic [AW-1:0]     addend;

    assign state = fsm;
    assign a_ext = {{2{mcand[QW-1]}}, mcand};
    assign two_a = {a_ext[AW-2:0], 1'b0};

    // Booth digit selection from the low multiplier pair and the previous bit.
    always_comb begin
        addend = '0;
        case ({q[1:0], qm1})
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = two_a;
            3'b100:         addend = -two_a;
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
    end

    // Controller: state, counter and every registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            counter <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (go) begin
                        fsm  <= LOAD;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    counter <= '0;
                    fsm     <= EVAL;
                end
                EVAL: fsm <= SHIFT;
                SHIFT: begin
                    counter <= counter + CW'(1);
                    if (counter == LAST) begin
                        fsm     <= DONE;
                        done    <= 1'b1;
                        // Low 2*WIDTH bits of {acc,Q} as they will stand after this shift.
                        product <= {acc[WIDTH-1:0], q[QW-1:2]};
                    end else begin
                        fsm <= EVAL;
                    end
                end
                DONE: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the datapath registers carry no reset; every field is rewritten in
    // IDLE/LOAD before it is consumed, and product is what the reset clears.
    always_ff @(posedge clk) begin
        case (fsm)
            IDLE: begin
                if (go) begin
                    a_cap  <= a;
                    b_cap  <= b;
                    sm_cap <= signed_mode;
                end
            end
            LOAD: begin
                mcand <= {{2{sm_cap & a_cap[WIDTH-1]}}, a_cap};
                q     <= {{2{sm_cap & b_cap[WIDTH-1]}}, b_cap};
                qm1   <= 1'b0;
                acc   <= '0;
            end
            EVAL: acc <= acc + addend;
            SHIFT: begin
                acc <= {{2{acc[AW-1]}}, acc[AW-1:2]};
                q   <= {acc[1:0], q[QW-1:2]};
                qm1 <= q[1];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Self-checking bench: WIDTH=8 directed cases, back-to-back throughput, reset abort,
// and WIDTH=16 random pairs against an integer-arithmetic reference.
module tb_booth_r4_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        go8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;
    logic [2:0]  st8;

    logic        go16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;
    logic [2:0]  st16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_r4_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .go(go8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(p8), .state(st8)
    );

    booth_r4_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .go(go16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(p16), .state(st16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact product of the two operands read as w-bit signed or unsigned integers.
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input bit sm, input int w);
        longint mask, sx, sy, p;
        mask = (longint'(1) << w) - 1;
        sx = longint'(x) & mask;
        sy = longint'(y) & mask;
        if (sm && sx >= (longint'(1) << (w - 1))) sx = sx - (longint'(1) << w);
        if (sm && sy >= (longint'(1) << (w - 1))) sy = sy - (longint'(1) << w);
        p = sx * sy;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic bsy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic dn(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [31:0] prod(input int w);
        return (w == 8) ? {16'h0, p8} : p16;
    endfunction

    // One complete operation; operands are scrambled right after capture.
    task automatic run_op(input int w, input logic [15:0] aa, input logic [15:0] bb,
                          input bit sm, input logic [31:0] exp, input string tag,
                          input bit full);
        int k, lat, bcnt, dcnt;
        logic [31:0] pr;
        if (w == 8) begin
            a8 = aa[7:0]; b8 = bb[7:0]; sm8 = sm; go8 = 1'b1;
        end else begin
            a16 = aa; b16 = bb; sm16 = sm; go16 = 1'b1;
        end
        tick();
        go8 = 1'b0; go16 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~sm;
        a16 = 16'($urandom); b16 = 16'($urandom); sm16 = ~sm;
        lat = 0; bcnt = 0; dcnt = 0; pr = '0; k = 0;
        while (k < 60) begin
            if (bsy(w)) bcnt++;
            if (dn(w)) begin
                dcnt++;
                if (dcnt == 1) begin
                    lat = k;
                    pr  = prod(w);
                end
            end
            if (!bsy(w) && k > 0) break;
            tick();
            k++;
        end
        check({tag, " product"}, 64'(pr), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(w + 3));
        if (full) begin
            check({tag, " busy cycles"}, 64'(bcnt), 64'(w + 4));
            check({tag, " done pulses"}, 64'(dcnt), 64'd1);
            check({tag, " product held"}, 64'(prod(w)), 64'(exp));
        end
    endtask

    logic [7:0] ta [3];
    logic [7:0] tbv [3];
    bit         tsm [3];
    int         exp_edge [$];
    logic [31:0] exp_prod [$];
    int         ndone;
    logic [15:0] ra, rb;
    bit          rs;

    initial begin
        ta  = '{8'h80, 8'hFF, 8'h5A};
        tbv = '{8'h80, 8'h01, 8'hC3};
        tsm = '{1'b1, 1'b0, 1'b1};

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        check("reset state8", 64'(st8), 64'd0);
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset product8", 64'(p8), 64'd0);
        check("reset state16", 64'(st16), 64'd0);
        rst = 1'b0;
        tick();

        // Directed WIDTH=8 corner cases.
        run_op(8, 16'h0080, 16'h0080, 1'b1, 32'h4000, "s8 -128*-128", 1'b1);
        run_op(8, 16'h00FF, 16'h00FF, 1'b0, 32'hFE01, "u8 ff*ff", 1'b1);
        run_op(8, 16'h00FF, 16'h00FF, 1'b1, 32'h0001, "s8 -1*-1", 1'b1);
        run_op(8, 16'h00FF, 16'h0001, 1'b1, 32'hFFFF, "s8 -1*1", 1'b1);
        run_op(8, 16'h0000, 16'h00A5, 1'b0, 32'h0000, "u8 0*a5", 1'b1);
        run_op(8, 16'h007F, 16'h0080, 1'b1, 32'hC080, "s8 127*-128", 1'b1);

        // go held high for 40 cycles; operand set rotates every cycle.
        for (int c = 0; c < 40; c += 13) begin
            exp_edge.push_back(c + 11);
            exp_prod.push_back(ref_mul({8'h0, ta[c % 3]}, {8'h0, tbv[c % 3]}, tsm[c % 3], 8));
        end
        ndone = 0;
        for (int e = 0; e < 56; e++) begin
            if (e < 40) begin
                a8 = ta[e % 3]; b8 = tbv[e % 3]; sm8 = tsm[e % 3]; go8 = 1'b1;
            end else begin
                go8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            end
            tick();
            if (done8) begin
                ndone++;
                if (exp_edge.size() > 0) begin
                    check("thru done edge", 64'(e), 64'(exp_edge.pop_front()));
                    check("thru product", 64'(p8), 64'(exp_prod.pop_front()));
                end
            end
        end
        check("thru done count", 64'(ndone), 64'd4);

        // Reset while in EVAL aborts the operation.
        a8 = 8'h37; b8 = 8'h5A; sm8 = 1'b1; go8 = 1'b1;
        tick();
        go8 = 1'b0;
        tick();
        check("abort pre state", 64'(st8), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort state", 64'(st8), 64'd0);
        check("abort busy", 64'(busy8), 64'd0);
        check("abort done", 64'(done8), 64'd0);
        check("abort product", 64'(p8), 64'd0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done8) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);
        run_op(8, 16'h0037, 16'h005A, 1'b1, ref_mul(16'h0037, 16'h005A, 1'b1, 8),
               "post-abort", 1'b1);

        // WIDTH=16 boundaries, then random pairs.
        run_op(16, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "s16 min*min", 1'b1);
        run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "u16 max*max", 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            run_op(16, ra, rb, rs, ref_mul(ra, rb, rs, 16), "rand16", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_r4_mult_seq.md
Name: booth_r4_mult_seq

Overview:
- Parametrised sequential radix-4 (modified Booth) multiplier: controller FSM and datapath merged into one block.
- Successor to the fixed-width radix-4 controller. The external `flag` loop-end input is replaced by an internal iteration counter.
- Adds WIDTH generalisation, runtime signed/unsigned mode, a busy/done handshake and a held product output.
- Sits between operand registers and the result consumer in the radix4 arithmetic path.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and ≥4; otherwise elaboration error.
- ITER, WIDTH/2+1, number of Booth iterations. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- go  in  1  start request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned. Captured with operands.
- a  in  WIDTH  multiplicand; captured in IDLE when go=1.
- b  in  WIDTH  multiplier; captured in IDLE when go=1.
- busy  out  1  high in LOAD, EVAL, SHIFT, DONE.
- done  out  1  one-cycle pulse, high only in DONE.
- product  out  2*WIDTH  result; registered, held until overwritten.
- state  out  3  FSM state for debug: IDLE=0, LOAD=1, EVAL=2, SHIFT=3, DONE=4.

Behaviour:
- Reset, applied on any clk edge with rst=1 and overriding everything:
  - state=IDLE, busy=0, done=0, product=0, counter=0.
  - Aborts an operation in progress. No partial product appears on product.
- IDLE: go=1 at the edge captures a, b and signed_mode, then moves to LOAD. go=0 stays in IDLE.
- go is ignored in every other state. No queuing.
- LOAD:
  - Extend both operands to WIDTH+2 bits: sign-extend if signed_mode=1, zero-extend otherwise.
  - Clear the accumulator (WIDTH+4 bits). Q = extended b, q_-1 = 0, counter=0.
  - Next state: EVAL.
- EVAL: Booth-decode {Q[1],Q[0],q_-1} and add to the accumulator:
  - 000 or 111 → add 0.
  - 001 or 010 → add +A.
  - 011 → add +2A.
  - 100 → add −2A.
  - 101 or 110 → add −A.
  - A is the sign-extended (WIDTH+2)-bit multiplicand.
  - Next state: SHIFT.
- SHIFT:
  - Arithmetic right shift of {acc,Q,q_-1} by 2; counter+1.
  - If counter==ITER-1 → DONE, else → EVAL.
- DONE:
  - product = low 2*WIDTH bits of {acc,Q} after the final shift. The result is exact in both modes; no overflow.
  - done=1 for this cycle only. Next state: IDLE.
- Latency:
  - go is sampled at edge E0.
  - done and the new product are visible after edge E0+1+2*ITER (WIDTH=8: E0+11).
  - IDLE is entered at E0+2+2*ITER.
- Throughput with go held high: one result every 2*ITER+3 cycles (WIDTH=8: 13).
- Product stability: product changes only on entry to DONE or on reset. busy and done are registered.
- Input stability: a, b and signed_mode may change freely after capture without affecting the result.
- Boundary cases: a=0 or b=0 gives 0. Signed most-negative × most-negative gives a positive exact result. Unsigned all-ones × all-ones gives the exact value.

Test Plan:
- WIDTH=8, signed, a=0x80 (−128), b=0x80 → product=0x4000. done pulses once, 11 edges after go sampled; busy high 12 cycles.
- WIDTH=8, unsigned, a=0xFF, b=0xFF → product=0xFE01. Same data, signed → product=0x0001 (−1×−1).
- WIDTH=8, signed, a=0xFF (−1), b=0x01 → 0xFFFF. Unsigned a=0x00, b=0xA5 → 0x0000.
- go held high for 40 cycles with three operand sets changing every cycle:
  - done pulses every 13 cycles.
  - Each product matches the operands sampled at its own IDLE edge.
  - Changes to a/b mid-op have no effect.
- rst=1 asserted for one cycle during EVAL:
  - Next cycle: state=0, busy=0, done=0, product=0.
  - No done pulse from the aborted op; a new go then completes normally.
- WIDTH=16, random 1000 signed and unsigned pairs against a reference model → exact match. Latency 19 edges.
